i2s_audio_out: RTL

//  Stereo I2S transmitter driving I2S_MCLK/SCLK/LRCLK/SDIN, which are currently tied low at top level.

---
 rtl/i2s_audio_out.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_audio_out.sv
// i2s_audio_out: stereo Philips-I2S transmitter fed from a sample FIFO.
// The CPU pushes {left[15:0], right[15:0]} words. One word is consumed per
// 64-SCLK frame; an empty FIFO at a frame boundary sends silence and raises
// the sticky underrun flag.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | enable low: I2S pins low, dividers and bit counter at zero
//   ST_RUN   | transmitting; the first clk of RUN is a frame boundary
module i2s_audio_out #(
  parameter int FIFO_AW  = 4,
  parameter int SCLK_DIV = 16,
  parameter int MCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      sample_d,
  input  logic             sample_we,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [FIFO_AW:0] fifo_count,
  output logic             underrun,
  output logic             overflow,
  input  logic             flags_clr,
  output logic             frame_pop,
  output logic             I2S_MCLK,
  output logic             I2S_SCLK,
  output logic             I2S_LRCLK,
  output logic             I2S_SDIN
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int DIV_W  = $clog2(SCLK_DIV);
  localparam int MDIV_W = $clog2(MCLK_DIV);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(SCLK_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
  localparam logic [MDIV_W-1:0] MDIV_LAST  = MDIV_W'(MCLK_DIV - 1);
  localparam logic [MDIV_W-1:0] MDIV_HALF  = MDIV_W'(MCLK_DIV / 2);
  localparam logic [MDIV_W-1:0] MDIV_ONE   = MDIV_W'(1);
  localparam logic [FIFO_AW:0]  COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  COUNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [DIV_W-1:0]   r_div;
  logic [MDIV_W-1:0]  r_mclk_cnt;
  logic [5:0]         r_bit;
  logic [63:0]        r_shreg;
  logic               r_mclk;
  logic               r_sclk;
  logic               r_lrclk;
  logic               r_sdin;
  logic               r_frame_pop;
  logic               r_underrun;
  logic               r_overflow;

  logic               w_running;
  logic               w_full;
  logic               w_empty;
  logic               w_boundary;
  logic               w_pop;
  logic               w_push;
  logic               w_div_wrap;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [MDIV_W-1:0]  w_mclk_nxt;
  logic [5:0]         w_bit_nxt;
  logic [5:0]         w_sdin_idx;
  logic [31:0]        w_frame;
  logic [63:0]        w_load;

  // Staying in RUN needs enable this cycle; dropping it discards the frame.
  assign w_running  = (r_state == ST_RUN) && enable;
  assign w_full     = (r_count == COUNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_boundary = w_running && (r_div == '0) && (r_bit == '0);
  assign w_pop      = w_boundary && !w_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is kept.
  assign w_push     = sample_we && (!w_full || w_pop);
  assign w_div_wrap = (r_div == DIV_LAST);

  // Next counter values; every counter sits at zero outside RUN.
  always_comb begin
    w_div_nxt  = '0;
    w_mclk_nxt = '0;
    w_bit_nxt  = '0;
    if (w_running) begin
      w_div_nxt  = w_div_wrap ? '0 : (r_div + DIV_ONE);
      w_mclk_nxt = (r_mclk_cnt == MDIV_LAST) ? '0 : (r_mclk_cnt + MDIV_ONE);
      w_bit_nxt  = w_div_wrap ? (r_bit + 6'd1) : r_bit;
    end
  end

  // Frame word: delay bit, 16 data bits, zero padding, per channel.
  always_comb begin
    w_frame    = w_empty ? 32'h0 : r_mem[r_rd_ptr];
    w_load     = {1'b0, w_frame[31:16], 15'b0, 1'b0, w_frame[15:0], 15'b0};
    w_sdin_idx = 6'd63 - w_bit_nxt;
  end

  // Run/idle state follows enable directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= enable ? ST_RUN : ST_IDLE;
    end
  end

  // Bit-clock divider, master-clock divider and frame bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_mclk_cnt <= '0;
      r_bit      <= '0;
    end else begin
      r_div      <= w_div_nxt;
      r_mclk_cnt <= w_mclk_nxt;
      r_bit      <= w_bit_nxt;
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame shift register: loaded at each boundary, cleared when leaving RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (w_boundary) begin
      r_shreg <= w_load;
    end else if (!enable) begin
      r_shreg <= '0;
    end
  end

  // I2S pins, registered from the next counter values so they line up with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mclk  <= 1'b0;
      r_sclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdin  <= 1'b0;
    end else if (!enable) begin
      r_mclk  <= 1'b0;
      r_sclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdin  <= 1'b0;
    end else begin
      r_mclk  <= (w_mclk_nxt < MDIV_HALF);
      r_sclk  <= (w_div_nxt >= DIV_HALF);
      r_lrclk <= w_bit_nxt[5];
      // Data only changes with the SCLK falling edge; bit 63 of the
      // frame word is always zero, so the boundary slot is silent.
      if (w_div_nxt == '0) begin
        r_sdin <= r_shreg[w_sdin_idx];
      end
    end
  end

  // Pop pulse and sticky status flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_pop <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_pop <= w_pop;
      if (w_boundary && w_empty) begin
        r_underrun <= 1'b1;
      end else if (flags_clr) begin
        r_underrun <= 1'b0;
      end
      if (sample_we && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (flags_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign fifo_count = r_count;
  assign underrun   = r_underrun;
  assign overflow   = r_overflow;
  assign frame_pop  = r_frame_pop;
  assign I2S_MCLK   = r_mclk;
  assign I2S_SCLK   = r_sclk;
  assign I2S_LRCLK  = r_lrclk;
  assign I2S_SDIN   = r_sdin;

endmodule
